parking_gate_controller: RTL and testbench

- Multi-gate successor to the single-entry parking checker.
- Tracks free spaces in a register. Arbitrates entry and exit requests from GATES gates. Drives a timed open pulse per gate.
- Sits between the gate sensors/buttons and the barrier actuators and display; free_spaces feeds the capacity display.

---
 rtl/parking_gate_controller.sv | 134 +++++++++++++
 tb/tb_parking_gate_controller.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/parking_gate_controller.sv
// Purpose: multi-gate parking controller; arbitrates exits and entries, keeps the free-space count and times each barrier.
// Latency: requests sampled before edge k produce grant/ack, the count update and the barrier opening at edge k.
// Backpressure: requests are level-held; a request at a busy gate, or beyond available room/occupancy, waits without being acknowledged.
module parking_gate_controller #(
    parameter int WIDTH       = 8,
    parameter int GATES       = 2,
    parameter int CAPACITY    = 200,
    parameter int OPEN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [GATES-1:0] entry,
    input  logic [GATES-1:0] exit,
    output logic [GATES-1:0] entry_grant,
    output logic [GATES-1:0] exit_ack,
    output logic [GATES-1:0] gate_open,
    output logic [WIDTH-1:0] free_spaces,
    output logic             full,
    output logic             empty
);

    // One extra bit so occupancy and per-cycle tallies never wrap.
    localparam int CNTW = WIDTH + 1;
    localparam int CW   = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
    localparam int PW   = (GATES > 1) ? $clog2(GATES) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN_IN  = 2'd1,
        OPEN_OUT = 2'd2
    } gate_state_t;

    gate_state_t       state_q   [GATES];
    gate_state_t       state_nxt [GATES];
    logic [CW-1:0]     cnt_q     [GATES];
    logic [CW-1:0]     cnt_nxt   [GATES];
    logic [PW-1:0]     rr_ptr_q;
    logic [PW-1:0]     rr_ptr_nxt;
    logic [WIDTH-1:0]  free_nxt;
    logic [GATES-1:0]  grant_nxt;
    logic [GATES-1:0]  ack_nxt;
    logic [GATES-1:0]  open_nxt;
    logic [CNTW-1:0]   occupancy;
    logic [CNTW-1:0]   ack_cnt;
    logic [CNTW-1:0]   grant_cnt;
    int                idx;

    // Both limits use the count at the start of the cycle, so spaces freed by
    // same-cycle exits only become grantable on the following cycle.
    assign occupancy = CNTW'(CAPACITY) - {1'b0, free_spaces};

    // Arbitration, per-gate FSM next state and counter update.
    always_comb begin
        ack_nxt    = '0;
        grant_nxt  = '0;
        open_nxt   = '0;
        ack_cnt    = '0;
        grant_cnt  = '0;
        rr_ptr_nxt = rr_ptr_q;
        idx        = 0;
        for (int i = 0; i < GATES; i++) begin
            state_nxt[i] = state_q[i];
            cnt_nxt[i]   = cnt_q[i];
        end

        // Exits: ascending gate index, never more than the cars inside.
        for (int i = 0; i < GATES; i++) begin
            if (exit[i] && (state_q[i] == IDLE) && (ack_cnt < occupancy)) begin
                ack_nxt[i] = 1'b1;
                ack_cnt    = ack_cnt + CNTW'(1);
            end
        end

        // Entries: round robin from the pointer; an exit on the same gate wins.
        for (int off = 0; off < GATES; off++) begin
            idx = (int'(rr_ptr_q) + off) % GATES;
            if (entry[idx] && (state_q[idx] == IDLE) && !ack_nxt[idx] &&
                (grant_cnt < {1'b0, free_spaces})) begin
                grant_nxt[idx] = 1'b1;
                grant_cnt      = grant_cnt + CNTW'(1);
                rr_ptr_nxt     = PW'((idx + 1) % GATES);
            end
        end

        // Barrier timers: loaded on grant/ack, close when the count hits zero.
        for (int i = 0; i < GATES; i++) begin
            if (state_q[i] == IDLE) begin
                if (ack_nxt[i]) begin
                    state_nxt[i] = OPEN_OUT;
                    cnt_nxt[i]   = CW'(OPEN_CYCLES - 1);
                end else if (grant_nxt[i]) begin
                    state_nxt[i] = OPEN_IN;
                    cnt_nxt[i]   = CW'(OPEN_CYCLES - 1);
                end
            end else if (cnt_q[i] == '0) begin
                state_nxt[i] = IDLE;
            end else begin
                cnt_nxt[i] = cnt_q[i] - CW'(1);
            end
            open_nxt[i] = (state_nxt[i] != IDLE);
        end

        free_nxt = free_spaces + WIDTH'(ack_cnt) - WIDTH'(grant_cnt);
    end

    // State, timers, pointer, count and pulse outputs; reset closes every gate at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < GATES; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            rr_ptr_q    <= '0;
            free_spaces <= WIDTH'(CAPACITY);
            entry_grant <= '0;
            exit_ack    <= '0;
            gate_open   <= '0;
        end else begin
            for (int i = 0; i < GATES; i++) begin
                state_q[i] <= state_nxt[i];
                cnt_q[i]   <= cnt_nxt[i];
            end
            rr_ptr_q    <= rr_ptr_nxt;
            free_spaces <= free_nxt;
            entry_grant <= grant_nxt;
            exit_ack    <= ack_nxt;
            gate_open   <= open_nxt;
        end
    end

    assign full  = (free_spaces == '0);
    assign empty = (free_spaces == WIDTH'(CAPACITY));

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller with GATES=2, CAPACITY=3, OPEN_CYCLES=2.
// Outputs are sampled 1 time unit after each rising edge; inputs change at that same point.
// Expected values are hand-derived from the behavioural description of the block.
module tb_parking_gate_controller;

    logic       clk;
    logic       reset;
    logic [1:0] entry;
    logic [1:0] exit;
    logic [1:0] entry_grant;
    logic [1:0] exit_ack;
    logic [1:0] gate_open;
    logic [7:0] free_spaces;
    logic       full;
    logic       empty;

    int tests  = 0;
    int failed = 0;

    parking_gate_controller #(
        .WIDTH(8), .GATES(2), .CAPACITY(3), .OPEN_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset), .entry(entry), .exit(exit),
        .entry_grant(entry_grant), .exit_ack(exit_ack), .gate_open(gate_open),
        .free_spaces(free_spaces), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant/ack/open/free all at once for a sampled cycle.
    task automatic chk4(input string tag, input logic [1:0] g, input logic [1:0] a,
                        input logic [1:0] o, input logic [7:0] f);
        chk({tag, ".grant"}, 8'(entry_grant), 8'(g));
        chk({tag, ".ack"},   8'(exit_ack),    8'(a));
        chk({tag, ".open"},  8'(gate_open),   8'(o));
        chk({tag, ".free"},  free_spaces,     f);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        entry = 2'b00;
        exit  = 2'b00;

        // Reset state
        tick();
        chk4("rst", 2'b00, 2'b00, 2'b00, 8'd3);
        chk("rst.empty", 8'(empty), 8'd1);
        chk("rst.full",  8'(full),  8'd0);
        reset = 1'b0;
        tick();
        chk4("idle", 2'b00, 2'b00, 2'b00, 8'd3);

        // Single entry at gate 0 for one cycle
        entry = 2'b01;
        tick();
        chk4("e0", 2'b01, 2'b00, 2'b01, 8'd2);
        chk("e0.empty", 8'(empty), 8'd0);
        entry = 2'b00;
        tick();
        chk4("e0.c2", 2'b00, 2'b00, 2'b01, 8'd2);
        tick();
        chk4("e0.c3", 2'b00, 2'b00, 2'b00, 8'd2);

        // Both gates requesting from reset
        pulse_reset();
        entry = 2'b11;
        tick();
        chk4("e11", 2'b11, 2'b00, 2'b11, 8'd1);
        tick();
        chk4("e11.c2", 2'b00, 2'b00, 2'b11, 8'd1);
        tick();
        chk4("e11.c3", 2'b00, 2'b00, 2'b00, 8'd1);
        tick();
        chk4("rr", 2'b01, 2'b00, 2'b01, 8'd0);
        chk("rr.full", 8'(full), 8'd1);
        entry = 2'b10;
        tick();
        chk4("full.blk", 2'b00, 2'b00, 2'b01, 8'd0);
        tick();
        chk4("full.blk2", 2'b00, 2'b00, 2'b00, 8'd0);

        // Full: exit at gate 0 with entry at gate 1 in the same cycle
        exit = 2'b01;
        tick();
        chk4("full.x", 2'b00, 2'b01, 2'b01, 8'd1);
        chk("full.x.full", 8'(full), 8'd0);
        exit = 2'b00;
        tick();
        chk4("full.e1", 2'b10, 2'b00, 2'b11, 8'd0);
        chk("full.e1.full", 8'(full), 8'd1);
        entry = 2'b00;

        // Empty lot: exits are refused
        pulse_reset();
        exit = 2'b11;
        tick();
        chk4("empty.x", 2'b00, 2'b00, 2'b00, 8'd3);
        chk("empty.x.empty", 8'(empty), 8'd1);

        // One car inside: two exits, only the lowest gate is accepted
        exit  = 2'b00;
        entry = 2'b01;
        tick();
        chk4("one.in", 2'b01, 2'b00, 2'b01, 8'd2);
        entry = 2'b00;
        tick();
        tick();
        chk4("one.idle", 2'b00, 2'b00, 2'b00, 8'd2);
        exit = 2'b11;
        tick();
        chk4("x11", 2'b00, 2'b01, 2'b01, 8'd3);
        exit = 2'b00;
        tick();
        tick();
        entry = 2'b10;
        tick();
        chk4("e1", 2'b10, 2'b00, 2'b10, 8'd2);

        // Same-gate entry and exit: exit wins
        entry = 2'b01;
        exit  = 2'b01;
        tick();
        chk4("same", 2'b00, 2'b01, 2'b11, 8'd3);
        entry = 2'b00;
        exit  = 2'b00;

        // Asynchronous reset while gate 0 is open
        #2;
        reset = 1'b1;
        #1;
        chk("arst.open",  8'(gate_open),   8'd0);
        chk("arst.free",  free_spaces,     8'd3);
        chk("arst.ack",   8'(exit_ack),    8'd0);
        chk("arst.empty", 8'(empty),       8'd1);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
